// File: rtl/brlite_tx_arbiter_if.sv
// Bundle between N_REQ BrLite transmit requesters, the arbiter and the local BrLite router port.
// master = arbiter side, slave = requesters/router side; data is carried flat and typed inside the arbiter.
interface brlite_tx_arbiter_if #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = 32
) ();
   localparam int GIDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]             req_i;
   logic [N_REQ-1:0][DATA_W-1:0] data_i;
   logic [N_REQ-1:0]             ack_o;
   logic                         br_local_busy_i;
   logic                         br_req_o;
   logic                         br_ack_i;
   logic [DATA_W-1:0]            br_data_o;
   logic [GIDX_W-1:0]            grant_idx_o;
   logic                         busy_o;

   modport master (
      input  req_i,
      input  data_i,
      input  br_local_busy_i,
      input  br_ack_i,
      output ack_o,
      output br_req_o,
      output br_data_o,
      output grant_idx_o,
      output busy_o
   );

   modport slave (
      output req_i,
      output data_i,
      output br_local_busy_i,
      output br_ack_i,
      input  ack_o,
      input  br_req_o,
      input  br_data_o,
      input  grant_idx_o,
      input  busy_o
   );
endinterface

// File: rtl/brlite_tx_arbiter.sv
// Round-robin arbiter feeding one BrLite packet at a time to the local router: 1-cycle req->br_req latency,
// holds the grant until br_ack_i, then enforces GAP_CYCLES idle cycles; br_local_busy_i stalls new grants only.
package brlite_pkg;
   typedef struct packed {
      logic [1:0] service;
      logic [5:0] seq;
      logic [7:0] src;
      logic [7:0] tgt;
      logic [7:0] payload;
   } brlite_out_t;
endpackage

module brlite_tx_arbiter
   import brlite_pkg::*;
#(
   parameter int N_REQ      = 3,
   parameter int GAP_CYCLES = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   brlite_tx_arbiter_if.master bus
);
   localparam int GIDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GIDX_W-1:0] LAST_RST = GIDX_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_br_req;
   logic [N_REQ-1:0]  r_ack;
   brlite_out_t       r_data;
   logic [GIDX_W-1:0] r_gidx;
   logic [GIDX_W-1:0] r_last;
   logic              r_busy;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_found;
   logic [GIDX_W-1:0] w_idx;
   logic [GIDX_W-1:0] w_winner;
   brlite_out_t       w_win_data;

   // Search starts just past the last acknowledged requester, so it ends up lowest priority.
   always_comb begin
      w_found  = 1'b0;
      w_idx    = '0;
      w_winner = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_idx = GIDX_W'((int'(r_last) + k) % N_REQ);
         if (!w_found && bus.req_i[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
      w_win_data = bus.data_i[w_winner];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_br_req <= 1'b0;
         r_ack    <= '0;
         r_data   <= '0;
         r_gidx   <= '0;
         r_last   <= LAST_RST;
         r_busy   <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found && !bus.br_local_busy_i) begin
                  r_state  <= S_REQ;
                  r_br_req <= 1'b1;
                  r_data   <= w_win_data;
                  r_gidx   <= w_winner;
                  r_busy   <= 1'b1;
               end
            end
            S_REQ: begin
               // The packet stays presented until the router takes it; nothing else can abort it.
               if (bus.br_ack_i) begin
                  r_br_req <= 1'b0;
                  r_ack    <= N_REQ'(1) << r_gidx;
                  r_last   <= r_gidx;
                  if (GAP_CYCLES == 0) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_GAP;
                     r_cnt   <= GAP_LOAD;
                  end
               end
            end
            S_GAP: begin
               r_cnt <= (r_cnt != '0) ? r_cnt - 1'b1 : '0;
               if (r_cnt <= CNT_W'(1)) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_br_req <= 1'b0;
               r_busy   <= 1'b0;
               r_cnt    <= '0;
            end
         endcase
      end
   end

   assign bus.br_req_o    = r_br_req;
   assign bus.ack_o       = r_ack;
   assign bus.br_data_o   = r_data;
   assign bus.grant_idx_o = r_gidx;
   assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_brlite_tx_arbiter.sv
// Bench for brlite_tx_arbiter: cycle vector table plus hand sequences for busy stall, hold-in-REQ,
// async reset and zero-gap operation; accepted packets are matched against a scoreboard queue.
module tb_brlite_tx_arbiter;
   import brlite_pkg::*;

   localparam int N  = 3;
   localparam int NV = 19;

   typedef struct {
      logic [2:0] req;
      logic       busy;
      logic       ack;
      logic       e_req;
      logic [1:0] e_gidx;
      logic [2:0] e_ack;
      logic       e_busy;
   } vec_t;

   typedef struct packed {
      logic [2:0]  ack;
      brlite_out_t dat;
   } sb_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   brlite_tx_arbiter_if #(.N_REQ(N)) b1 ();
   brlite_tx_arbiter_if #(.N_REQ(N)) b0 ();

   brlite_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(2)) u_dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (b1)
   );

   brlite_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(0)) u_dut_g0 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (b0)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   brlite_out_t dat [N];
   vec_t        tbl [NV];
   sb_t         sb_q [$];
   sb_t         sb_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      for (int c = 0; c < 20; c++) begin
         step();
         if (!b1.busy_o) break;
      end
      chk(name, b1.busy_o, 1'b0);
   endtask

   // Every accepted packet must be the next one the bench expects.
   always @(negedge clk) begin
      if (rst_n && b1.ack_o != '0) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected_ack: got ack_o=%b, required no ack", b1.ack_o);
         end else begin
            sb_e = sb_q.pop_front();
            chk("sb_ack", b1.ack_o, sb_e.ack);
            chk("sb_data", b1.br_data_o, sb_e.dat);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       m_req;
      logic       m_ack;
      logic [2:0] prev_ack;

      dat[0] = 32'h4110_2AA0;
      dat[1] = 32'h4211_2BA1;
      dat[2] = 32'h4312_2CA2;
      b1.req_i = '0; b1.br_local_busy_i = 1'b0; b1.br_ack_i = 1'b0;
      b0.req_i = '0; b0.br_local_busy_i = 1'b0; b0.br_ack_i = 1'b0;
      b1.data_i = {dat[2], dat[1], dat[0]};
      b0.data_i = {dat[2], dat[1], dat[0]};

      //            req    bsy   ack    e_req e_gidx e_ack   e_busy
      tbl[0]  = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0};
      tbl[1]  = '{3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0};
      tbl[2]  = '{3'b111, 1'b0, 1'b0, 1'b1, 2'd0, 3'b000, 1'b1};
      tbl[3]  = '{3'b111, 1'b0, 1'b1, 1'b0, 2'd0, 3'b001, 1'b1};
      tbl[4]  = '{3'b111, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000, 1'b1};
      tbl[5]  = '{3'b110, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0};
      tbl[6]  = '{3'b110, 1'b0, 1'b0, 1'b1, 2'd1, 3'b000, 1'b1};
      tbl[7]  = '{3'b110, 1'b0, 1'b1, 1'b0, 2'd1, 3'b010, 1'b1};
      tbl[8]  = '{3'b100, 1'b0, 1'b0, 1'b0, 2'd1, 3'b000, 1'b1};
      tbl[9]  = '{3'b100, 1'b0, 1'b0, 1'b0, 2'd1, 3'b000, 1'b0};
      tbl[10] = '{3'b101, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000, 1'b1};
      tbl[11] = '{3'b101, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000, 1'b1};
      tbl[12] = '{3'b001, 1'b0, 1'b1, 1'b0, 2'd2, 3'b100, 1'b1};
      tbl[13] = '{3'b001, 1'b0, 1'b0, 1'b0, 2'd2, 3'b000, 1'b1};
      tbl[14] = '{3'b001, 1'b0, 1'b0, 1'b0, 2'd2, 3'b000, 1'b0};
      tbl[15] = '{3'b001, 1'b0, 1'b0, 1'b1, 2'd0, 3'b000, 1'b1};
      tbl[16] = '{3'b001, 1'b0, 1'b1, 1'b0, 2'd0, 3'b001, 1'b1};
      tbl[17] = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1};
      tbl[18] = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_br_req", b1.br_req_o, 1'b0);
      chk("rst_ack", b1.ack_o, 3'b000);
      chk("rst_data", b1.br_data_o, 32'h0);
      chk("rst_gidx", b1.grant_idx_o, 2'd0);
      chk("rst_busy", b1.busy_o, 1'b0);
      rst_n = 1'b1;

      // Round-robin 0,1,2,0 with the 2-cycle gap, busy stall and stray router acks.
      for (int i = 0; i < NV; i++) begin
         b1.req_i           = tbl[i].req;
         b1.br_local_busy_i = tbl[i].busy;
         b1.br_ack_i        = tbl[i].ack;
         if (tbl[i].e_ack != 3'b000)
            sb_q.push_back('{ack: tbl[i].e_ack, dat: dat[tbl[i].e_gidx]});
         step();
         chk($sformatf("v%0d_br_req", i), b1.br_req_o, tbl[i].e_req);
         chk($sformatf("v%0d_gidx", i), b1.grant_idx_o, tbl[i].e_gidx);
         chk($sformatf("v%0d_ack", i), b1.ack_o, tbl[i].e_ack);
         chk($sformatf("v%0d_busy", i), b1.busy_o, tbl[i].e_busy);
         if (tbl[i].e_req)
            chk($sformatf("v%0d_data", i), b1.br_data_o, dat[tbl[i].e_gidx]);
      end
      b1.req_i = '0; b1.br_ack_i = 1'b0; b1.br_local_busy_i = 1'b0;

      // Local port busy for 5 cycles holds requester 1 off.
      b1.req_i = 3'b010;
      b1.br_local_busy_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("busyhold_br_req", b1.br_req_o, 1'b0);
         chk("busyhold_busy_o", b1.busy_o, 1'b0);
      end
      b1.br_local_busy_i = 1'b0;
      step();
      chk("busyfall_br_req", b1.br_req_o, 1'b1);
      chk("busyfall_gidx", b1.grant_idx_o, 2'd1);
      chk("busyfall_data", b1.br_data_o, dat[1]);
      sb_q.push_back('{ack: 3'b010, dat: dat[1]});
      b1.br_ack_i = 1'b1;
      step();
      chk("busyfall_ack", b1.ack_o, 3'b010);
      b1.br_ack_i = 1'b0;
      b1.req_i = '0;
      wait_idle("busyfall_idle");

      // Grant to 2 survives req drop, data change, busy and a competing request.
      b1.req_i = 3'b100;
      step();
      chk("hold_grant_req", b1.br_req_o, 1'b1);
      chk("hold_grant_gidx", b1.grant_idx_o, 2'd2);
      b1.req_i = 3'b001;
      b1.data_i[2] = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         b1.br_local_busy_i = c[0];
         step();
         chk("hold_br_req", b1.br_req_o, 1'b1);
         chk("hold_data", b1.br_data_o, dat[2]);
         chk("hold_gidx", b1.grant_idx_o, 2'd2);
         chk("hold_ack", b1.ack_o, 3'b000);
      end
      sb_q.push_back('{ack: 3'b100, dat: dat[2]});
      b1.br_ack_i = 1'b1;
      b1.br_local_busy_i = 1'b0;
      step();
      chk("hold_ack_pulse", b1.ack_o, 3'b100);
      chk("hold_br_req_drop", b1.br_req_o, 1'b0);
      b1.br_ack_i = 1'b0;
      b1.req_i = '0;
      step();
      chk("hold_ack_one_cycle", b1.ack_o, 3'b000);
      b1.data_i[2] = dat[2];
      wait_idle("hold_idle");

      // Move last grant to 0, then reset mid-grant of requester 1.
      b1.req_i = 3'b001;
      step();
      chk("pre_rst_gidx", b1.grant_idx_o, 2'd0);
      sb_q.push_back('{ack: 3'b001, dat: dat[0]});
      b1.br_ack_i = 1'b1;
      step();
      b1.br_ack_i = 1'b0;
      b1.req_i = '0;
      wait_idle("pre_rst_idle");
      b1.req_i = 3'b010;
      step();
      chk("inflight_br_req", b1.br_req_o, 1'b1);
      chk("inflight_gidx", b1.grant_idx_o, 2'd1);
      b1.br_ack_i = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_br_req", b1.br_req_o, 1'b0);
      chk("async_rst_busy", b1.busy_o, 1'b0);
      chk("async_rst_data", b1.br_data_o, 32'h0);
      chk("async_rst_gidx", b1.grant_idx_o, 2'd0);
      chk("async_rst_ack", b1.ack_o, 3'b000);
      b1.br_ack_i = 1'b0;
      b1.req_i = 3'b011;
      step();
      chk("in_rst_br_req", b1.br_req_o, 1'b0);
      rst_n = 1'b1;
      step();
      chk("post_rst_br_req", b1.br_req_o, 1'b1);
      chk("post_rst_gidx", b1.grant_idx_o, 2'd0);
      chk("post_rst_data", b1.br_data_o, dat[0]);
      chk("post_rst_ack", b1.ack_o, 3'b000);
      sb_q.push_back('{ack: 3'b001, dat: dat[0]});
      b1.br_ack_i = 1'b1;
      step();
      b1.br_ack_i = 1'b0;
      b1.req_i = '0;
      wait_idle("post_rst_idle");

      // Zero gap: requester 0 held, router acking every cycle.
      b0.req_i = 3'b001;
      b0.br_ack_i = 1'b1;
      m_req = 1'b0;
      prev_ack = 3'b000;
      for (int c = 0; c < 8; c++) begin
         m_ack = m_req;
         m_req = !m_req;
         step();
         chk("g0_br_req", b0.br_req_o, m_req);
         chk("g0_ack", b0.ack_o, m_ack ? 3'b001 : 3'b000);
         chk("g0_gidx", b0.grant_idx_o, 2'd0);
         chk("g0_no_merge", prev_ack & b0.ack_o, 3'b000);
         if (m_req) chk("g0_data", b0.br_data_o, dat[0]);
         prev_ack = b0.ack_o;
      end
      b0.req_i = '0;
      b0.br_ack_i = 1'b0;
      repeat (2) step();
      chk("g0_idle", b0.busy_o, 1'b0);

      repeat (2) step();
      chk("sb_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/brlite_tx_arbiter.md
BRLITE_TX_ARBITER -- requirements
Module: brlite_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of BrLite transmit requesters, legal range 2..8.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles enforced after each completed transmission, legal range 0..255.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  N_REQ  per-requester level request to transmit one BrLite packet.
REQ-006 data_i  input  N_REQ x brlite_out_t  per-requester packet; held stable while that req_i is high.
REQ-007 ack_o  output  N_REQ  one-cycle pulse to a requester when its packet is accepted by the BrLite router.
REQ-008 br_local_busy_i  input  1  local BrLite port busy; no new grant is issued while high.
REQ-009 br_req_o  output  1  request to the BrLite router.
REQ-010 br_ack_i  input  1  router acceptance of br_data_o.
REQ-011 br_data_o  output  brlite_out_t  registered packet presented to the router.
REQ-012 grant_idx_o  output  max(1,$clog2(N_REQ))  index of the current or last granted requester.
REQ-013 busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, REQ, GAP.
REQ-015 IDLE exit: any req_i high and br_local_busy_i low.
- Winner: round-robin, first requester with req_i high, searching from (last_grant+1) mod N_REQ upward with wrap-around.
- Same edge: br_data_o <= data_i[winner], grant_idx_o <= winner, br_req_o <= 1, next state REQ.
- Latency: br_req_o is high one cycle after the qualifying req_i.
REQ-016 IDLE hold: any req_i high with br_local_busy_i high: remain in IDLE, no output change.
REQ-017 REQ state: br_req_o and br_data_o held constant until br_ack_i.
- req_i deassertion, br_local_busy_i, and other requesters have no effect.
- A granted packet is never aborted.
REQ-018 br_ack_i sampled high in REQ, same edge:
- br_req_o <= 0.
- ack_o[grant_idx_o] <= 1 for exactly one cycle.
- last_grant <= grant_idx_o.
- Next state GAP with gap counter <= GAP_CYCLES, or IDLE directly if GAP_CYCLES == 0.
REQ-019 GAP state: counter decrements by 1 per cycle; when it reaches 0, next state IDLE.
- Counter width $clog2(GAP_CYCLES+1), minimum 1 bit; no underflow.
- req_i is ignored during GAP.
REQ-020 Requester protocol: each requester drops req_i in the cycle after its ack_o pulse.
- The arbiter tolerates req_i still high in that cycle: it is in GAP or IDLE, and IDLE re-arbitration rotates priority past that requester.
REQ-021 br_ack_i outside REQ is ignored.
REQ-022 ack_o is never asserted for more than one requester in the same cycle.
REQ-023 Only one packet is outstanding at any time.
REQ-024 br_data_o changes only on the IDLE->REQ transition.

Reset
REQ-025 Reset values:
- State IDLE; br_req_o 0; ack_o all 0; br_data_o all 0; grant_idx_o 0; busy_o 0; gap counter 0.
- last_grant N_REQ-1, so requester 0 has first priority.
REQ-026 Reset asserted in REQ or GAP returns all outputs to reset values immediately (asynchronous), and any in-flight grant is discarded without an ack_o pulse.

Verification
REQ-027 N_REQ=3, GAP_CYCLES=2; req_i=3'b111 held, router acks 1 cycle after each br_req_o -> grants 0,1,2,0 in order; 2 idle cycles between each ack_o and the next br_req_o.
REQ-028 req_i[1]=1 with br_local_busy_i=1 for 5 cycles, then 0 -> br_req_o rises exactly 1 cycle after busy falls; br_data_o==data_i[1]; grant_idx_o==1.
REQ-029 In REQ for requester 2, drop req_i[2] and change data_i[2] -> br_req_o stays 1 and br_data_o unchanged until br_ack_i; then ack_o=3'b100 for one cycle.
REQ-030 GAP_CYCLES=0, req_i[0] held continuously with ack every cycle -> requester 0 re-granted; IDLE->REQ cycle visible between packets; ack_o[0] pulses never merge.
REQ-031 Assert rst_ni low while br_req_o=1 -> br_req_o, busy_o, and br_data_o go to 0 without waiting for a clock edge; no ack_o pulse; after release, first grant goes to the lowest-index active requester.
REQ-032 br_ack_i pulsed in IDLE and in GAP -> no ack_o, no state change.
